// File: rtl/decode_issue.sv
// Decode-and-issue stage: decodes a MIPS subset, reads operands with writeback bypass,
// tracks outstanding writes in a scoreboard and issues a registered ALU bundle.
module decode_issue #(
  parameter logic [31:0] RESET_PC = 32'h0,
  localparam int unsigned ALU_OPT_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_valid,
  input  logic [31:0]              if_instr,
  input  logic [31:0]              if_pc,
  output logic                     if_ready,
  output logic [4:0]               rf_raddr1,
  output logic [4:0]               rf_raddr2,
  input  logic [31:0]              rf_rdata1,
  input  logic [31:0]              rf_rdata2,
  input  logic                     wb_en,
  input  logic [4:0]               wb_addr,
  input  logic [31:0]              wb_data,
  input  logic                     ex_ready,
  output logic                     ex_valid,
  output logic [ALU_OPT_WIDTH-1:0] ex_opt,
  output logic [31:0]              ex_opr1,
  output logic [31:0]              ex_opr2,
  output logic [4:0]               ex_dest,
  output logic                     ex_wb_en,
  input  logic                     flush,
  output logic                     trap,
  output logic [31:0]              trap_pc
);

  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_DISABLE = 4'd0;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_ADDU    = 4'd1;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_SUBU    = 4'd2;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_OR      = 4'd3;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_SETU    = 4'd4;

  typedef enum logic [0:0] {StRun, StTrap} state_e;

  state_e state_q, state_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  assign opcode = if_instr[31:26];
  assign rs     = if_instr[25:21];
  assign rt     = if_instr[20:16];
  assign rd     = if_instr[15:11];
  assign imm16  = if_instr[15:0];
  assign funct  = if_instr[5:0];

  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  logic                     dec_legal, dec_use_rs, dec_use_rt, dec_wr;
  logic [ALU_OPT_WIDTH-1:0] dec_opt;
  logic [4:0]               dec_dest;
  logic [31:0]              dec_imm;

  always_comb begin
    dec_legal  = 1'b0;
    dec_use_rs = 1'b0;
    dec_use_rt = 1'b0;
    dec_wr     = 1'b0;
    dec_opt    = ALU_OPT_DISABLE;
    dec_dest   = 5'd0;
    dec_imm    = 32'h0;
    if (if_instr == 32'h0) begin
      dec_legal = 1'b1;
    end else begin
      case (opcode)
        6'h00: begin
          if (funct == 6'h21 || funct == 6'h23 || funct == 6'h25) begin
            dec_legal  = 1'b1;
            dec_use_rs = 1'b1;
            dec_use_rt = 1'b1;
            dec_wr     = 1'b1;
            dec_dest   = rd;
            dec_opt    = (funct == 6'h21) ? ALU_OPT_ADDU :
                         (funct == 6'h23) ? ALU_OPT_SUBU : ALU_OPT_OR;
          end
        end
        6'h09: begin
          dec_legal  = 1'b1;
          dec_use_rs = 1'b1;
          dec_wr     = 1'b1;
          dec_dest   = rt;
          dec_opt    = ALU_OPT_ADDU;
          dec_imm    = {{16{imm16[15]}}, imm16};
        end
        6'h0D: begin
          dec_legal  = 1'b1;
          dec_use_rs = 1'b1;
          dec_wr     = 1'b1;
          dec_dest   = rt;
          dec_opt    = ALU_OPT_OR;
          dec_imm    = {16'h0, imm16};
        end
        6'h0F: begin
          dec_legal = 1'b1;
          dec_wr    = 1'b1;
          dec_dest  = rt;
          dec_opt   = ALU_OPT_SETU;
          dec_imm   = {imm16, 16'h0};
        end
        default: ;
      endcase
    end
  end

  logic        bypass_rs, bypass_rt, dec_wb_en;
  logic [31:0] rs_val, rt_val, opr1, opr2;

  assign bypass_rs = wb_en && (wb_addr == rs);
  assign bypass_rt = wb_en && (wb_addr == rt);
  assign rs_val    = (rs == 5'd0) ? 32'h0 : bypass_rs ? wb_data : rf_rdata1;
  assign rt_val    = (rt == 5'd0) ? 32'h0 : bypass_rt ? wb_data : rf_rdata2;
  assign opr1      = dec_use_rs ? rs_val : 32'h0;
  assign opr2      = dec_use_rt ? rt_val : dec_imm;
  assign dec_wb_en = dec_wr && (dec_dest != 5'd0);

  logic [31:0] busy_q, busy_d;
  logic        hazard, accept, issue;

  // A writeback landing this cycle both bypasses the data and releases the hazard.
  assign hazard = (dec_use_rs && busy_q[rs] && !bypass_rs) ||
                  (dec_use_rt && busy_q[rt] && !bypass_rt);

  assign if_ready = (state_q == StRun) && !flush && !hazard && (!ex_valid || ex_ready);
  assign accept   = if_valid && if_ready;
  assign issue    = accept && dec_legal;

  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_addr] = 1'b0;
    if (flush && ex_valid && ex_wb_en) busy_d[ex_dest] = 1'b0;
    // Set is applied last so it wins over a same-cycle clear.
    if (issue && dec_wb_en) busy_d[dec_dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (accept && !dec_legal) state_d = StTrap;
      StTrap:  if (flush) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      busy_q   <= 32'h0;
      trap     <= 1'b0;
      trap_pc  <= RESET_PC;
      ex_valid <= 1'b0;
      ex_opt   <= ALU_OPT_DISABLE;
      ex_opr1  <= 32'h0;
      ex_opr2  <= 32'h0;
      ex_dest  <= 5'd0;
      ex_wb_en <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      if (state_q == StTrap && flush) begin
        trap <= 1'b0;
      end else if (accept && !dec_legal) begin
        trap    <= 1'b1;
        trap_pc <= if_pc;
      end
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (issue) begin
        ex_valid <= 1'b1;
        ex_opt   <= dec_opt;
        ex_opr1  <= opr1;
        ex_opr2  <= opr2;
        ex_dest  <= dec_dest;
        ex_wb_en <= dec_wb_en;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule
